// File: rtl/seq_detect_prog_pkg.sv
// Shared definitions for the programmable serial pattern detector:
// detection mode encoding and legal parameter ranges.
package seq_detect_prog_pkg;

    typedef enum logic {
        MODE_NONOVL = 1'b0,
        MODE_OVL    = 1'b1
    } mode_e;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;
    localparam int CNT_W_MIN = 1;
    localparam int CNT_W_MAX = 16;

endpackage

// File: rtl/seq_detect_prog_sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment in the
// same cycle leave the counter at one (clear first, then count).
module seq_detect_prog_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    // NOTE: sequential state is always updated with <= so every flop samples
    // the pre-edge values of its inputs, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? CNT_W'(1) : '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector: pulses z one cycle after the last
// PAT_W valid bits equal the loaded pattern, and counts matches.
module seq_detect_prog
    import seq_detect_prog_pkg::*;
#(
    parameter int  PAT_W  = 4,
    parameter int  CNT_W  = 8,
    localparam int FILL_W = $clog2(PAT_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              x_valid,
    input  logic              x,
    input  logic              overlap,
    input  logic              pat_load,
    input  logic [PAT_W-1:0]  pat_in,
    input  logic              cnt_clr,
    output logic              z,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [FILL_W-1:0] progress
);

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  history;
    logic [PAT_W-1:0]  pattern;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  new_hist;
    logic [FILL_W-1:0] new_fill;
    logic              match;

    // Match is judged on the history/fill this sample would produce.
    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        new_hist = history;
        new_fill = fill;
        match    = 1'b0;
        if (!pat_load && x_valid) begin
            new_hist = {history[PAT_W-2:0], x};
            new_fill = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
            match    = (new_hist == pattern) && (new_fill == FILL_FULL);
        end
    end

    // NOTE: pattern and history are register arrays but still get reset, so
    // the detector behaves as an all-zeros detector straight out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pattern <= '0;
            history <= '0;
            fill    <= '0;
            z       <= 1'b0;
        end else if (pat_load) begin
            pattern <= pat_in;
            history <= '0;
            fill    <= '0;
            z       <= 1'b0;
        end else begin
            history <= new_hist;
            z       <= match;
            fill    <= (match && (mode_e'(overlap) == MODE_NONOVL)) ? '0 : new_fill;
        end
    end

    seq_detect_prog_sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match),
        .clr   (cnt_clr),
        .cnt   (match_cnt)
    );

    assign progress = fill;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench for seq_detect_prog: directed scenarios plus random
// stream, compared against a queue-based model of the last valid bits.
module tb_seq_detect_prog;

    localparam int PAT_W = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       x_valid = 1'b0;
    logic       x = 1'b0;
    logic       overlap = 1'b0;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = '0;
    logic       cnt_clr = 1'b0;

    logic       z_a, z_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic [2:0] prog_a, prog_b;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: bits seen since last restart, loaded pattern, outputs.
    bit       m_q[$];
    bit [3:0] m_pat = '0;
    bit       m_z = 1'b0;
    int       m_cnt_a = 0;
    int       m_cnt_b = 0;

    always #5 clk = ~clk;

    seq_detect_prog #(.PAT_W(PAT_W), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .x_valid(x_valid), .x(x), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .z(z_a), .match_cnt(cnt_a), .progress(prog_a)
    );

    seq_detect_prog #(.PAT_W(PAT_W), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .x_valid(x_valid), .x(x), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .z(z_b), .match_cnt(cnt_b), .progress(prog_b)
    );

    function automatic int m_prog();
        return (m_q.size() > PAT_W) ? PAT_W : m_q.size();
    endfunction

    function automatic logic [23:0] observed();
        return {z_a, z_b, cnt_a, cnt_b, 4'(prog_a), 4'(prog_b), 4'd0};
    endfunction

    function automatic logic [23:0] expected();
        return {m_z, m_z, 8'(m_cnt_a), 2'(m_cnt_b), 4'(m_prog()), 4'(m_prog()), 4'd0};
    endfunction

    // Drive one cycle of inputs, clock it, then advance the model.
    task automatic cycle(input logic rst, input logic ld, input logic [3:0] pi,
                         input logic clr, input logic ov, input logic v, input logic xb);
        bit matched;
        bit [3:0] last;
        reset = rst; pat_load = ld; pat_in = pi; cnt_clr = clr;
        overlap = ov; x_valid = v; x = xb;
        @(posedge clk);
        #1;
        matched = 1'b0;
        if (rst) begin
            m_q.delete(); m_pat = '0; m_z = 1'b0; m_cnt_a = 0; m_cnt_b = 0;
        end else begin
            if (ld) begin
                m_pat = pi;
                m_q.delete();
            end else if (v) begin
                m_q.push_back(xb);
                if (m_q.size() > PAT_W) void'(m_q.pop_front());
                if (m_q.size() == PAT_W) begin
                    last = {m_q[0], m_q[1], m_q[2], m_q[3]};
                    matched = (last == m_pat);
                end
                if (matched && !ov) m_q.delete();
            end
            m_z = matched;
            if (clr) begin
                m_cnt_a = matched ? 1 : 0;
                m_cnt_b = matched ? 1 : 0;
            end else if (matched) begin
                if (m_cnt_a < 255) m_cnt_a++;
                if (m_cnt_b < 3) m_cnt_b++;
            end
        end
    endtask

    task automatic test_reset();
        cycle(1, 0, 4'h0, 0, 0, 0, 0);
        n_checks++;
        if (observed() !== expected())
            $display("FAIL reset: z=%b/%b cnt=%0d/%0d prog=%0d/%0d, required z=0 cnt=0 prog=0",
                     z_a, z_b, cnt_a, cnt_b, prog_a, prog_b);
        else n_pass++;
    endtask

    task automatic run_stream(input string name, input logic ov, input int bits[]);
        for (int i = 0; i < bits.size(); i++) begin
            cycle(0, 0, 4'h0, 0, ov, 1, bits[i][0]);
            n_checks++;
            if (observed() !== expected())
                $display("FAIL %s bit%0d: got z=%b cnt=%0d/%0d prog=%0d, required z=%b cnt=%0d/%0d prog=%0d",
                         name, i + 1, z_a, cnt_a, cnt_b, prog_a, m_z, m_cnt_a, m_cnt_b, m_prog());
            else n_pass++;
        end
    endtask

    task automatic test_nonoverlap();
        cycle(0, 1, 4'b1011, 1, 0, 0, 0);
        run_stream("nonoverlap", 0, '{1, 0, 1, 1, 0, 1, 1});
        n_checks++;
        if (cnt_a !== 8'd1) $display("FAIL nonoverlap_count: got %0d, required 1", cnt_a);
        else n_pass++;
    endtask

    task automatic test_overlap();
        cycle(0, 1, 4'b1011, 1, 1, 0, 0);
        run_stream("overlap", 1, '{1, 0, 1, 1, 0, 1, 1});
        n_checks++;
        if (cnt_a !== 8'd2) $display("FAIL overlap_count: got %0d, required 2", cnt_a);
        else n_pass++;
    endtask

    task automatic test_gaps();
        int bits[4] = '{1, 0, 1, 1};
        cycle(0, 1, 4'b1011, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 4'h0, 0, 0, 1, bits[i][0]);
            for (int g = 0; g < 4; g++) begin
                if (g > 0) cycle(0, 0, 4'h0, 0, 0, 0, 1'($urandom));
                n_checks++;
                if (observed() !== expected())
                    $display("FAIL gaps bit%0d gap%0d: got z=%b cnt=%0d prog=%0d, required z=%b cnt=%0d prog=%0d",
                             i + 1, g, z_a, cnt_a, prog_a, m_z, m_cnt_a, m_prog());
                else n_pass++;
            end
        end
    endtask

    task automatic test_load_midstream();
        cycle(0, 1, 4'b1011, 1, 0, 0, 0);
        run_stream("preload", 0, '{1, 0, 1});
        cycle(0, 1, 4'b0110, 0, 0, 1, 1);
        n_checks++;
        if (prog_a !== 3'd0 || z_a !== 1'b0)
            $display("FAIL load_clears: got prog=%0d z=%b, required prog=0 z=0", prog_a, z_a);
        else n_pass++;
        run_stream("postload", 0, '{0, 1, 1, 0});
    endtask

    task automatic test_saturate();
        cycle(0, 1, 4'b1111, 1, 1, 0, 0);
        run_stream("saturate", 1, '{1, 1, 1, 1, 1, 1, 1, 1});
        n_checks++;
        if (cnt_b !== 2'd3) $display("FAIL saturate_count: got %0d, required 3", cnt_b);
        else n_pass++;
        cycle(0, 0, 4'h0, 1, 1, 1, 1);
        n_checks++;
        if (cnt_a !== 8'd1 || cnt_b !== 2'd1 || z_a !== 1'b1)
            $display("FAIL clear_with_match: got cnt=%0d/%0d z=%b, required cnt=1/1 z=1",
                     cnt_a, cnt_b, z_a);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        cycle(0, 1, 4'b1011, 0, 0, 0, 0);
        run_stream("prereset", 0, '{1, 0, 1});
        cycle(1, 0, 4'h0, 0, 0, 1, 1);
        n_checks++;
        if (z_a !== 1'b0 || cnt_a !== 8'd0 || prog_a !== 3'd0)
            $display("FAIL reset_midstream: got z=%b cnt=%0d prog=%0d, required 0 0 0",
                     z_a, cnt_a, prog_a);
        else n_pass++;
        run_stream("zero_pattern", 0, '{0, 0, 0, 0});
    endtask

    task automatic test_random();
        logic rst, ld, clr;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            ld  = ($urandom_range(0, 39) == 0);
            clr = ($urandom_range(0, 29) == 0);
            cycle(rst, ld, 4'($urandom), clr, 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 3) != 0), 1'($urandom));
            n_checks++;
            if (observed() !== expected())
                $display("FAIL random cyc%0d: got z=%b cnt=%0d/%0d prog=%0d, required z=%b cnt=%0d/%0d prog=%0d",
                         i, z_a, cnt_a, cnt_b, prog_a, m_z, m_cnt_a, m_cnt_b, m_prog());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_nonoverlap();
        test_overlap();
        test_gaps();
        test_load_midstream();
        test_saturate();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
